// File: rtl/arbitro_wrr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arbitro_wrr_pkg
// Purpose  : Shared transaction-layer constants for the weighted round-robin
//            arbiter: class count, FSM state encoding, default class weights
//            and a small class-index helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package arbitro_wrr_pkg;

  localparam int c_NUM_CLASS = 4;

  localparam int c_DEF_WEIGHT_0 = 4;
  localparam int c_DEF_WEIGHT_1 = 3;
  localparam int c_DEF_WEIGHT_2 = 2;
  localparam int c_DEF_WEIGHT_3 = 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

  // Next class in round-robin order; wraps 3 -> 0 through 2-bit overflow.
  function automatic logic [1:0] next_class(input logic [1:0] c);
    return c + 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arbitro_wrr_if.sv
`default_nettype none
// ============================================================================
// Module   : arbitro_wrr_if
// Purpose  : Bundles the class-FIFO bank side and the downstream FIFO side of
//            the arbiter.
// Ports    : Enable, FIFO_empty[3:0], data_in_0..3, Almost_full (to arbiter)
//            Pop[3:0], Push, data_out, grant_id, busy          (from arbiter)
//            modport slave  - arbiter view
//            modport master - environment view
// Revision : 1.0 - initial release
// ============================================================================
interface arbitro_wrr_if #(
  parameter int DATA_W = 6
) ();

  logic              Enable;
  logic [3:0]        FIFO_empty;
  logic [DATA_W-1:0] data_in_0;
  logic [DATA_W-1:0] data_in_1;
  logic [DATA_W-1:0] data_in_2;
  logic [DATA_W-1:0] data_in_3;
  logic              Almost_full;
  logic [3:0]        Pop;
  logic              Push;
  logic [DATA_W-1:0] data_out;
  logic [1:0]        grant_id;
  logic              busy;

  modport slave (
    input  Enable, FIFO_empty, data_in_0, data_in_1, data_in_2, data_in_3,
           Almost_full,
    output Pop, Push, data_out, grant_id, busy
  );

  modport master (
    output Enable, FIFO_empty, data_in_0, data_in_1, data_in_2, data_in_3,
           Almost_full,
    input  Pop, Push, data_out, grant_id, busy
  );

endinterface
`default_nettype wire

// File: rtl/arbitro_wrr_rr_pick4.sv
`default_nettype none
// ============================================================================
// Module   : arbitro_wrr_rr_pick4
// Purpose  : Combinational 4-way round-robin picker. Returns the first
//            requesting index found searching ptr, ptr+1, ... (mod 4).
// Ports    : req[3:0] - request vector
//            ptr[1:0] - search start index
//            valid    - at least one request present
//            idx[1:0] - selected index (equals ptr when no request)
// Revision : 1.0 - initial release
// ============================================================================
module arbitro_wrr_rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       valid,
  output logic [1:0] idx
);

  logic [1:0] w_cand;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    valid  = 1'b0;
    idx    = ptr;
    w_cand = ptr;
    for (int i = 3; i >= 0; i--) begin
      w_cand = ptr + 2'(i);
      if (req[w_cand]) begin
        valid = 1'b1;
        idx   = w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/arbitro_wrr.sv
`default_nettype none
// ============================================================================
// Module   : arbitro_wrr
// Purpose  : Weighted round-robin arbiter draining four class FIFOs into one
//            downstream FIFO. A class keeps the grant for up to WEIGHT_n
//            consecutive pops; the popped word is registered and pushed
//            downstream one cycle later.
// Ports    : clk   - clock, posedge
//            reset - synchronous active-high reset
//            bus   - arbitro_wrr_if.slave (FIFO flags/data in, Pop/Push/
//                    data_out/grant_id/busy out)
// Revision : 1.0 - initial release
// ============================================================================
module arbitro_wrr
  import arbitro_wrr_pkg::*;
#(
  parameter int DATA_W   = 6,
  parameter int WEIGHT_0 = c_DEF_WEIGHT_0,
  parameter int WEIGHT_1 = c_DEF_WEIGHT_1,
  parameter int WEIGHT_2 = c_DEF_WEIGHT_2,
  parameter int WEIGHT_3 = c_DEF_WEIGHT_3
) (
  input  logic           clk,
  input  logic           reset,
  arbitro_wrr_if.slave   bus
);

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_rr_ptr, w_rr_ptr_nxt;
  logic [1:0]        r_gnt, w_gnt_nxt;
  logic [3:0]        r_burst_cnt, w_burst_cnt_nxt;
  logic [3:0]        w_pop;
  logic [1:0]        w_pop_idx;
  logic              w_pop_ok;
  logic              w_pick_valid;
  logic [1:0]        w_pick_idx;
  logic [DATA_W-1:0] w_data_sel;
  logic              r_push;
  logic [DATA_W-1:0] r_data_out;
  logic [1:0]        r_grant_id;

  function automatic logic [4:0] weight_of(input logic [1:0] c);
    case (c)
      2'd0:    return 5'(WEIGHT_0);
      2'd1:    return 5'(WEIGHT_1);
      2'd2:    return 5'(WEIGHT_2);
      default: return 5'(WEIGHT_3);
    endcase
  endfunction

  assign w_pop_ok = bus.Enable & ~reset & ~bus.Almost_full;

  arbitro_wrr_rr_pick4 u_pick (
    .req   (~bus.FIFO_empty),
    .ptr   (r_rr_ptr),
    .valid (w_pick_valid),
    .idx   (w_pick_idx)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_gnt_nxt       = r_gnt;
    w_burst_cnt_nxt = r_burst_cnt;
    w_pop           = 4'b0000;
    w_pop_idx       = r_gnt;
    case (r_state)
      ST_IDLE: begin
        if (w_pop_ok && w_pick_valid) begin
          w_pop_idx          = w_pick_idx;
          w_pop[w_pick_idx]  = 1'b1;
          // A weight-1 class is a complete burst on its own; skip SERVE.
          if (weight_of(w_pick_idx) == 5'd1) begin
            w_rr_ptr_nxt = next_class(w_pick_idx);
          end else begin
            w_gnt_nxt       = w_pick_idx;
            w_burst_cnt_nxt = 4'd1;
            w_state_nxt     = ST_SERVE;
          end
        end
      end
      ST_SERVE: begin
        if (bus.Enable && !reset) begin
          if (bus.FIFO_empty[r_gnt]) begin
            // Early release: the granted class ran dry before its weight.
            w_state_nxt     = ST_IDLE;
            w_rr_ptr_nxt    = next_class(r_gnt);
            w_burst_cnt_nxt = 4'd0;
          end else if (!bus.Almost_full) begin
            w_pop[r_gnt] = 1'b1;
            if ({1'b0, r_burst_cnt} + 5'd1 == weight_of(r_gnt)) begin
              w_state_nxt     = ST_IDLE;
              w_rr_ptr_nxt    = next_class(r_gnt);
              w_burst_cnt_nxt = 4'd0;
            end else begin
              w_burst_cnt_nxt = r_burst_cnt + 4'd1;
            end
          end
          // Almost_full with data present: stall, grant and count held.
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    case (w_pop_idx)
      2'd0:    w_data_sel = bus.data_in_0;
      2'd1:    w_data_sel = bus.data_in_1;
      2'd2:    w_data_sel = bus.data_in_2;
      default: w_data_sel = bus.data_in_3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= 2'd0;
      r_gnt       <= 2'd0;
      r_burst_cnt <= 4'd0;
      r_push      <= 1'b0;
      r_data_out  <= '0;
      r_grant_id  <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_gnt       <= w_gnt_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
      r_push      <= |w_pop;
      if (|w_pop) begin
        r_data_out <= w_data_sel;
        r_grant_id <= w_pop_idx;
      end
    end
  end

  assign bus.Pop      = w_pop;
  assign bus.Push     = r_push;
  assign bus.data_out = r_data_out;
  assign bus.grant_id = r_grant_id;
  assign bus.busy     = (r_state == ST_SERVE);

endmodule
`default_nettype wire

// File: tb/tb_arbitro_wrr.sv
`default_nettype none
// ============================================================================
// Module   : tb_arbitro_wrr
// Purpose  : Directed self-checking bench for arbitro_wrr. The class FIFOs
//            are modelled as word counters with a head index; each word is
//            {class, index}. Expected Pop/busy per cycle are hand-computed
//            tables; expected Push/data_out/grant_id follow one cycle later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arbitro_wrr;

  localparam int DATA_W = 6;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  arbitro_wrr_if #(.DATA_W(DATA_W)) bus ();

  arbitro_wrr #(
    .DATA_W   (DATA_W),
    .WEIGHT_0 (4),
    .WEIGHT_1 (3),
    .WEIGHT_2 (2),
    .WEIGHT_3 (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  int         fcnt  [4];
  logic [3:0] fhead [4];

  logic              exp_push;
  logic [DATA_W-1:0] exp_dout;
  logic [1:0]        exp_gid;

  function automatic logic [1:0] idx_of(input logic [3:0] oh);
    case (oh)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic drive_fifos();
    logic [3:0] e;
    for (int n = 0; n < 4; n++) e[n] = (fcnt[n] == 0);
    bus.FIFO_empty = e;
    bus.data_in_0  = {2'd0, fhead[0]};
    bus.data_in_1  = {2'd1, fhead[1]};
    bus.data_in_2  = {2'd2, fhead[2]};
    bus.data_in_3  = {2'd3, fhead[3]};
  endtask

  // One clock cycle, entered and left at a negedge.
  task automatic cyc(input logic [3:0] ep, input logic eb, input string tag, input int k);
    logic [1:0] g;
    checks++;
    if (bus.Push !== exp_push) begin
      errors++;
      $display("FAIL %s[%0d] Push got %b exp %b", tag, k, bus.Push, exp_push);
    end
    checks++;
    if (bus.data_out !== exp_dout) begin
      errors++;
      $display("FAIL %s[%0d] data_out got %h exp %h", tag, k, bus.data_out, exp_dout);
    end
    checks++;
    if (bus.grant_id !== exp_gid) begin
      errors++;
      $display("FAIL %s[%0d] grant_id got %0d exp %0d", tag, k, bus.grant_id, exp_gid);
    end
    drive_fifos();
    #1;
    checks++;
    if (bus.Pop !== ep) begin
      errors++;
      $display("FAIL %s[%0d] Pop got %b exp %b", tag, k, bus.Pop, ep);
    end
    checks++;
    if (bus.busy !== eb) begin
      errors++;
      $display("FAIL %s[%0d] busy got %b exp %b", tag, k, bus.busy, eb);
    end
    if (reset) begin
      exp_push = 1'b0;
      exp_dout = '0;
      exp_gid  = 2'd0;
    end else if (ep != 4'b0000) begin
      g        = idx_of(ep);
      exp_push = 1'b1;
      exp_gid  = g;
      exp_dout = {g, fhead[g]};
      fhead[g] = fhead[g] + 4'd1;
      fcnt[g]  = fcnt[g] - 1;
    end else begin
      exp_push = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    bus.Enable      = 1'b1;
    bus.Almost_full = 1'b0;
    for (int n = 0; n < 4; n++) begin
      fcnt[n]  = 0;
      fhead[n] = 4'd0;
    end
    drive_fifos();
    @(negedge clk);
    reset    = 1'b0;
    exp_push = 1'b0;
    exp_dout = '0;
    exp_gid  = 2'd0;
  endtask

  task automatic test_reset();
    reset           = 1'b1;
    bus.Enable      = 1'b0;
    bus.Almost_full = 1'b0;
    for (int n = 0; n < 4; n++) begin
      fcnt[n]  = 0;
      fhead[n] = 4'd0;
    end
    drive_fifos();
    repeat (2) @(negedge clk);
    checks++;
    if (bus.Push !== 1'b0 || bus.data_out !== '0 || bus.grant_id !== 2'd0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs got push=%b dout=%h gid=%0d busy=%b exp 0/00/0/0",
               bus.Push, bus.data_out, bus.grant_id, bus.busy);
    end
    // Reset overrides Enable even with every class holding data.
    bus.Enable = 1'b1;
    for (int n = 0; n < 4; n++) fcnt[n] = 3;
    drive_fifos();
    #1;
    checks++;
    if (bus.Pop !== 4'b0000) begin
      errors++;
      $display("FAIL reset_pop got %b exp 0000", bus.Pop);
    end
  endtask

  task automatic test_single_class();
    logic [3:0] ep [7] = '{4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0};
    logic       eb [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    fcnt[1] = 5;
    for (int k = 0; k < 7; k++) cyc(ep[k], eb[k], "single", k);
  endtask

  task automatic test_full_rotation();
    logic [3:0] ep [10] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8};
    logic       eb [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int n = 0; n < 4; n++) fcnt[n] = 10;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 10; k++) cyc(ep[k], eb[k], "rotation", r * 10 + k);
  endtask

  task automatic test_stall();
    logic [3:0] ep [8] = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0};
    logic       eb [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    fcnt[0] = 2;
    for (int k = 0; k < 8; k++) begin
      bus.Almost_full = (k >= 1 && k <= 4);
      cyc(ep[k], eb[k], "stall", k);
    end
    bus.Almost_full = 1'b0;
  endtask

  task automatic test_early_release();
    logic [3:0] ep [5] = '{4'h4, 4'h0, 4'h8, 4'h8, 4'h0};
    logic       eb [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    fcnt[2] = 1;
    fcnt[3] = 2;
    for (int k = 0; k < 5; k++) cyc(ep[k], eb[k], "release", k);
  endtask

  task automatic test_enable_hold();
    logic [3:0] ep [8] = '{4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h1};
    logic       eb [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    fcnt[0] = 6;
    for (int k = 0; k < 8; k++) begin
      bus.Enable = !(k >= 2 && k <= 4);
      cyc(ep[k], eb[k], "enable", k);
    end
    bus.Enable = 1'b1;
  endtask

  task automatic test_back_to_back_reset();
    logic [3:0] ep [4] = '{4'h1, 4'h0, 4'h1, 4'h1};
    logic       eb [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    fcnt[0] = 5;
    fcnt[1] = 2;
    for (int k = 0; k < 4; k++) begin
      reset = (k == 1);
      cyc(ep[k], eb[k], "midreset", k);
    end
    reset = 1'b0;
  endtask

  initial begin
    exp_push = 1'b0;
    exp_dout = '0;
    exp_gid  = 2'd0;
    test_reset();
    test_single_class();
    test_full_rotation();
    test_stall();
    test_early_release();
    test_enable_hold();
    test_back_to_back_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
